// File: rtl/uart_pkg.sv
// Shared defaults and error-bit offsets for the UART receive FIFO.
// Build option: UART_RX_FIFO_ERR_STORE_EN keeps errored frames with their flags.
package uart_pkg;

  localparam int unsigned UART_DATA_WD    = 8;
  localparam int unsigned UART_FIFO_DEPTH = 16;

  // Error flags sit directly above the data bits of a stored entry.
  localparam int unsigned UART_FERR_OFS = 0;
  localparam int unsigned UART_PERR_OFS = 1;
  localparam int unsigned UART_ERR_BITS = 2;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Receiver-side and consumer-side signals of the UART receive FIFO.
// Build option: UART_RX_FIFO_ERR_STORE_EN adds dout_ferr/dout_perr.
interface uart_rx_fifo_if
  import uart_pkg::*;
#(
  parameter int unsigned data_wd = UART_DATA_WD,
  parameter int unsigned depth   = UART_FIFO_DEPTH
) ();

  logic                       rx_done;
  logic [data_wd-1:0]         rx_data;
  logic                       framing_error_flag;
  logic                       parity_error_flag;
  logic                       rd_en;
  logic                       clr_overrun;
  logic [data_wd-1:0]         dout;
  logic                       dout_valid;
  logic                       empty;
  logic                       full;
  logic [$clog2(depth):0]     count;
  logic                       overrun;
`ifdef UART_RX_FIFO_ERR_STORE_EN
  logic                       dout_ferr;
  logic                       dout_perr;
`endif

  modport master (
    output rx_done, rx_data, framing_error_flag, parity_error_flag, rd_en, clr_overrun,
`ifdef UART_RX_FIFO_ERR_STORE_EN
    input  dout_ferr, dout_perr,
`endif
    input  dout, dout_valid, empty, full, count, overrun
  );

  modport slave (
    input  rx_done, rx_data, framing_error_flag, parity_error_flag, rd_en, clr_overrun,
`ifdef UART_RX_FIFO_ERR_STORE_EN
    output dout_ferr, dout_perr,
`endif
    output dout, dout_valid, empty, full, count, overrun
  );

endinterface

// File: rtl/uart_fifo_mem.sv
// Simple dual-port storage: synchronous write port, registered read port.
module uart_fifo_mem #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     we_i,
  input  logic [$clog2(Depth)-1:0] waddr_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic                     re_i,
  input  logic [$clog2(Depth)-1:0] raddr_i,
  output logic [Width-1:0]         rdata_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read register holds its value when no read is issued.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: one write per rx_done rising edge, registered reads, sticky overrun.
// Build option: UART_RX_FIFO_ERR_STORE_EN stores errored frames with their flags.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned data_wd = UART_DATA_WD,
  parameter int unsigned depth   = UART_FIFO_DEPTH
) (
  input logic           clk,
  input logic           rst,
  uart_rx_fifo_if.slave bus
);

  localparam int unsigned AddrWd = $clog2(depth);
  localparam int unsigned CntWd  = AddrWd + 1;
`ifdef UART_RX_FIFO_ERR_STORE_EN
  localparam int unsigned EntryWd = data_wd + UART_ERR_BITS;
`else
  localparam int unsigned EntryWd = data_wd;
`endif

  logic               rx_done_q;
  logic               armed_q;
  logic               wr_pend_q;
  logic [EntryWd-1:0] wr_entry_q;
  logic [EntryWd-1:0] cap_entry;
  logic               cap_ok;
  logic               rise;

  logic [AddrWd-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AddrWd-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntWd-1:0]   count_q, count_d;
  logic               full_q, full_d;
  logic               empty_q, empty_d;
  logic               overrun_q, overrun_d;
  logic               dout_valid_q;
  logic               do_wr, do_rd, drop;
  logic [EntryWd-1:0] rd_entry;

`ifdef UART_RX_FIFO_ERR_STORE_EN
  always_comb begin
    cap_entry                           = '0;
    cap_entry[data_wd-1:0]              = bus.rx_data;
    cap_entry[data_wd + UART_FERR_OFS]  = bus.framing_error_flag;
    cap_entry[data_wd + UART_PERR_OFS]  = bus.parity_error_flag;
  end
  assign cap_ok = 1'b1;
`else
  assign cap_entry = bus.rx_data;
  assign cap_ok    = ~(bus.framing_error_flag | bus.parity_error_flag);
`endif

  // armed_q blocks a frame whose rx_done was already high when reset released.
  assign rise = bus.rx_done & ~rx_done_q & armed_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_done_q  <= 1'b0;
      armed_q    <= 1'b0;
      wr_pend_q  <= 1'b0;
      wr_entry_q <= '0;
    end else begin
      rx_done_q <= bus.rx_done;
      armed_q   <= armed_q | ~bus.rx_done;
      wr_pend_q <= rise & cap_ok;
      if (rise) begin
        wr_entry_q <= cap_entry;
      end
    end
  end

  always_comb begin
    do_rd     = bus.rd_en & ~empty_q;
    do_wr     = wr_pend_q & (~full_q | do_rd);
    drop      = wr_pend_q & full_q & ~do_rd;
    wr_ptr_d  = do_wr ? wr_ptr_q + AddrWd'(1) : wr_ptr_q;
    rd_ptr_d  = do_rd ? rd_ptr_q + AddrWd'(1) : rd_ptr_q;
    count_d   = count_q + CntWd'(do_wr) - CntWd'(do_rd);
    full_d    = (count_d == CntWd'(depth));
    empty_d   = (count_d == '0);
    overrun_d = overrun_q;
    if (drop) begin
      overrun_d = 1'b1;
    end else if (bus.clr_overrun) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
      overrun_q    <= 1'b0;
      dout_valid_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      full_q       <= full_d;
      empty_q      <= empty_d;
      overrun_q    <= overrun_d;
      dout_valid_q <= do_rd;
    end
  end

  uart_fifo_mem #(
    .Width (EntryWd),
    .Depth (depth)
  ) u_mem (
    .clk_i   (clk),
    .rst_i   (rst),
    .we_i    (do_wr),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_entry_q),
    .re_i    (do_rd),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_entry)
  );

  assign bus.dout       = rd_entry[data_wd-1:0];
  assign bus.dout_valid = dout_valid_q;
  assign bus.empty      = empty_q;
  assign bus.full       = full_q;
  assign bus.count      = count_q;
  assign bus.overrun    = overrun_q;
`ifdef UART_RX_FIFO_ERR_STORE_EN
  assign bus.dout_ferr  = rd_entry[data_wd + UART_FERR_OFS];
  assign bus.dout_perr  = rd_entry[data_wd + UART_PERR_OFS];
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: queue reference model, directed and random traffic.
module tb_uart_rx_fifo;
  import uart_pkg::*;

  localparam int unsigned DW    = UART_DATA_WD;
  localparam int unsigned DEPTH = UART_FIFO_DEPTH;
`ifdef UART_RX_FIFO_ERR_STORE_EN
  localparam bit ERR_STORE = 1'b1;
`else
  localparam bit ERR_STORE = 1'b0;
`endif

  typedef logic [DW+1:0] entry_t;  // {perr, ferr, data}

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_rx_fifo_if #(.data_wd(DW), .depth(DEPTH)) bus ();

  uart_rx_fifo #(.data_wd(DW), .depth(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO contents as a queue, reads in flight as a queue.
  entry_t     m_q[$];
  entry_t     exp_q[$];
  bit         m_pend;
  entry_t     m_pend_val;
  bit         m_prev;
  bit         m_seen_low;
  bit         m_ovr;
  bit         m_rd;
  logic [DW-1:0] m_dout;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      exp_q.delete();
      m_pend     = 1'b0;
      m_prev     = 1'b0;
      m_seen_low = 1'b0;
      m_ovr      = 1'b0;
      m_dout     = '0;
    end else begin
      m_rd = bus.rd_en && (m_q.size() != 0);
      if (m_rd) exp_q.push_back(m_q.pop_front());
      if (m_pend && m_q.size() == DEPTH) m_ovr = 1'b1;
      else begin
        if (m_pend) m_q.push_back(m_pend_val);
        if (bus.clr_overrun) m_ovr = 1'b0;
      end
      m_pend = bus.rx_done && !m_prev && m_seen_low &&
               (ERR_STORE || !(bus.framing_error_flag || bus.parity_error_flag));
      m_pend_val = {bus.parity_error_flag, bus.framing_error_flag, bus.rx_data};
      m_prev = bus.rx_done;
      if (!bus.rx_done) m_seen_low = 1'b1;
    end
  end

  // Monitor: compares DUT outputs against the model away from the active edge.
  entry_t e;
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.dout_valid) begin
        if (exp_q.size() == 0) check("dout_valid_unexpected", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          check("dout", 32'(bus.dout), 32'(e[DW-1:0]));
`ifdef UART_RX_FIFO_ERR_STORE_EN
          check("dout_ferr", 32'(bus.dout_ferr), 32'(e[DW]));
          check("dout_perr", 32'(bus.dout_perr), 32'(e[DW+1]));
`endif
          m_dout = e[DW-1:0];
        end
      end else begin
        check("dout_held", 32'(bus.dout), 32'(m_dout));
      end
      check("count", 32'(bus.count), 32'(m_q.size()));
      check("full", 32'(bus.full), 32'(m_q.size() == DEPTH));
      check("empty", 32'(bus.empty), 32'(m_q.size() == 0));
      check("overrun", 32'(bus.overrun), 32'(m_ovr));
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [DW-1:0] d, input bit f, input bit p, input int hold);
    @(negedge clk);
    bus.rx_done = 1'b1;
    bus.rx_data = d;
    bus.framing_error_flag = f;
    bus.parity_error_flag  = p;
    repeat (hold - 1) begin
      @(negedge clk);
      bus.rx_data = DW'($urandom);
      bus.framing_error_flag = 1'($urandom);
      bus.parity_error_flag  = 1'($urandom);
    end
    @(negedge clk);
    bus.rx_done = 1'b0;
    bus.rx_data = DW'($urandom);
    bus.framing_error_flag = 1'b0;
    bus.parity_error_flag  = 1'b0;
  endtask

  task automatic rd_pulse();
    @(negedge clk);
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
  endtask

  initial begin
    bus.rx_done = 1'b0;
    bus.rx_data = '0;
    bus.framing_error_flag = 1'b0;
    bus.parity_error_flag  = 1'b0;
    bus.rd_en = 1'b0;
    bus.clr_overrun = 1'b0;
    idle(3);
    check("rst_empty", 32'(bus.empty), 32'd1);
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_dout", 32'(bus.dout), 32'd0);
    check("rst_valid", 32'(bus.dout_valid), 32'd0);
    check("rst_overrun", 32'(bus.overrun), 32'd0);
    rst = 1'b0;
    idle(2);

    // Single frame with a long rx_done level.
    send(8'hA5, 1'b0, 1'b0, 5);
    idle(1);
    check("a5_count", 32'(bus.count), 32'd1);
    rd_pulse();
    idle(2);

    // Fill, overflow, clear, then full write+read.
    for (int i = 0; i < 16; i++) send(DW'(i), 1'b0, 1'b0, 1);
    send(8'hFF, 1'b0, 1'b0, 1);
    idle(1);
    check("fill_full", 32'(bus.full), 32'd1);
    check("fill_overrun", 32'(bus.overrun), 32'd1);
    check("fill_count", 32'(bus.count), 32'd16);
    @(negedge clk) bus.clr_overrun = 1'b1;
    @(negedge clk) bus.clr_overrun = 1'b0;
    check("clr_overrun", 32'(bus.overrun), 32'd0);
    @(negedge clk);
    bus.rx_done = 1'b1;
    bus.rx_data = 8'h77;
    @(negedge clk);
    bus.rx_done = 1'b0;
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
    check("full_rw_count", 32'(bus.count), 32'd16);
    check("full_rw_overrun", 32'(bus.overrun), 32'd0);
    for (int i = 0; i < 17; i++) rd_pulse();
    idle(2);

    // Errored frames.
    send(8'h3C, 1'b0, 1'b1, 2);
    idle(1);
    check("perr_count", 32'(bus.count), ERR_STORE ? 32'd1 : 32'd0);
    rd_pulse();
    send(8'h5A, 1'b1, 1'b0, 1);
    rd_pulse();
    idle(2);

    // Reset with stored data and a frame rising during reset.
    for (int i = 0; i < 5; i++) send(DW'(8'h40 + i), 1'b0, 1'b0, 1);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("async_rst_empty", 32'(bus.empty), 32'd1);
    check("async_rst_count", 32'(bus.count), 32'd0);
    bus.rx_done = 1'b1;
    bus.rx_data = 8'hEE;
    idle(2);
    rst = 1'b0;
    idle(3);
    bus.rx_done = 1'b0;
    idle(2);
    check("rst_frame_dropped", 32'(bus.count), 32'd0);
    rd_pulse();
    idle(2);

    // Interleaved traffic across pointer wrap.
    for (int i = 0; i < 40; i++) begin
      send(DW'(i), 1'b0, 1'b0, 1);
      if (i >= 3) rd_pulse();
    end
    for (int i = 0; i < 4; i++) rd_pulse();
    idle(2);
    check("wrap_drained", 32'(bus.count), 32'd0);

    // Random traffic: slow reads first (overflow likely), then fast reads.
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      bus.rx_done = ($urandom_range(0, 2) != 0);
      bus.rx_data = DW'($urandom);
      bus.framing_error_flag = ($urandom_range(0, 7) == 0);
      bus.parity_error_flag  = ($urandom_range(0, 7) == 0);
      bus.rd_en = (c < 300) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 0);
      bus.clr_overrun = ($urandom_range(0, 15) == 0);
    end
    @(negedge clk);
    bus.rx_done = 1'b0;
    bus.clr_overrun = 1'b0;
    bus.rd_en = 1'b1;
    idle(DEPTH + 4);
    bus.rd_en = 1'b0;
    idle(3);
    check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    check("final_empty", 32'(bus.empty), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
